// File: rtl/pc_gen_if.sv
// Request/response bundle between the IF-stage PC generator and its controllers.
// Optional misalign reporting signals exist only when PC_ALIGN_CHK_EN is defined.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall_PC;
  logic            br_valid;
  logic [XLEN-1:0] br_target;
  logic            jmp_valid;
  logic [XLEN-1:0] jmp_target;
  logic            trap_valid;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus;
  logic            pc_valid;
  logic [1:0]      state;
`ifdef PC_ALIGN_CHK_EN
  logic            misalign_err;
  logic [XLEN-1:0] bad_addr;
`endif

  modport master (
    output stall_PC, br_valid, br_target, jmp_valid, jmp_target,
    output trap_valid, halt_req, resume,
`ifdef PC_ALIGN_CHK_EN
    input  misalign_err, bad_addr,
`endif
    input  pc_out, pc_plus, pc_valid, state
  );

  modport slave (
    input  stall_PC, br_valid, br_target, jmp_valid, jmp_target,
    input  trap_valid, halt_req, resume,
`ifdef PC_ALIGN_CHK_EN
    output misalign_err, bad_addr,
`endif
    output pc_out, pc_plus, pc_valid, state
  );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: prioritised redirects, stall, boot delay, halt/resume FSM.
// Optional PC_ALIGN_CHK_EN turns misaligned br/jmp targets into a trap with misalign_err/bad_addr.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC          = 4,
  parameter int              BOOT_WAIT    = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  pif
);
  localparam logic [1:0] BOOT = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  localparam int CNT_W = (BOOT_WAIT < 2) ? 1 : $clog2(BOOT_WAIT);

  logic [XLEN-1:0]  pc_q;
  logic             vld_q;
  logic [1:0]       state_q;
  logic [CNT_W-1:0] boot_cnt;
  logic             boot_done;

  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  redir_tgt;
  logic             redir_sel;
  logic [XLEN-1:0]  next_pc;

`ifdef PC_ALIGN_CHK_EN
  logic             misalign;
  logic             err_q;
  logic [XLEN-1:0]  bad_q;
`endif

  // BOOT_WAIT==0 leaves BOOT on the first edge after reset release.
  assign boot_done = (BOOT_WAIT == 0) || (boot_cnt == CNT_W'(BOOT_WAIT - 1));

  assign seq_pc    = pc_q + XLEN'(INC);
  assign redir_sel = pif.br_valid | pif.jmp_valid;
  assign redir_tgt = pif.br_valid ? pif.br_target : pif.jmp_target;

  // Next PC in RUN: trap > branch > jump > stall-hold > sequential.
  always_comb begin
    next_pc = seq_pc;
`ifdef PC_ALIGN_CHK_EN
    misalign = 1'b0;
`endif
    if (pif.trap_valid) begin
      next_pc = TRAP_VECTOR;
    end else if (redir_sel) begin
`ifdef PC_ALIGN_CHK_EN
      misalign = |redir_tgt[1:0];
      next_pc  = misalign ? TRAP_VECTOR : redir_tgt;
`else
      next_pc  = {redir_tgt[XLEN-1:2], 2'b00};
`endif
    end else if (pif.stall_PC) begin
      next_pc = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      vld_q    <= 1'b0;
      state_q  <= BOOT;
      boot_cnt <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          if (boot_done) begin
            state_q <= RUN;
            vld_q   <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          // halt still lets this cycle's next PC land
          pc_q <= next_pc;
          if (pif.halt_req) begin
            state_q <= HALT;
            vld_q   <= 1'b0;
          end
        end
        HALT: begin
          if (pif.trap_valid) begin
            pc_q    <= TRAP_VECTOR;
            state_q <= RUN;
            vld_q   <= 1'b1;
          end else if (pif.resume) begin
            state_q <= RUN;
            vld_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHK_EN
  // misalign is already suppressed by trap_valid inside the priority mux.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
      bad_q <= '0;
    end else begin
      err_q <= (state_q == RUN) && misalign;
      if ((state_q == RUN) && misalign) bad_q <= redir_tgt;
    end
  end

  assign pif.misalign_err = err_q;
  assign pif.bad_addr     = bad_q;
`endif

  assign pif.pc_out   = pc_q;
  assign pif.pc_plus  = seq_pc;
  assign pif.pc_valid = vld_q;
  assign pif.state    = state_q;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each step pushes its expected PC/valid/state and pops it after the edge.
module tb_pc_gen;
  localparam logic [1:0] BOOT = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) pif();

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .INC(4), .BOOT_WAIT(4)
  ) dut (
    .clk(clk), .reset(reset), .pif(pif.slave)
  );

  typedef struct {
    logic        rst, st, br, jmp, trp, hlt, rsm;
    logic [31:0] bt, jt;
    logic [31:0] pc;
    logic        vld;
    logic [1:0]  s;
  } step_t;

  step_t exp_q[$];
  int checks = 0;
  int passes = 0;

  function automatic step_t s(input logic rst, st, br, jmp, trp, hlt, rsm,
                              input logic [31:0] bt, jt, pc,
                              input logic vld, input logic [1:0] stt);
    step_t r;
    r.rst = rst; r.st = st; r.br = br; r.jmp = jmp; r.trp = trp; r.hlt = hlt; r.rsm = rsm;
    r.bt = bt; r.jt = jt; r.pc = pc; r.vld = vld; r.s = stt;
    return r;
  endfunction

  task automatic drive(input step_t t);
    reset          = t.rst;
    pif.stall_PC   = t.st;
    pif.br_valid   = t.br;
    pif.jmp_valid  = t.jmp;
    pif.trap_valid = t.trp;
    pif.halt_req   = t.hlt;
    pif.resume     = t.rsm;
    pif.br_target  = t.bt;
    pif.jmp_target = t.jt;
    exp_q.push_back(t);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    step_t t[$];
    step_t e;
    t.push_back(s(0,0,0,0,0,0,0, 0, 0, 32'h0, 0, BOOT));
    t.push_back(s(0,1,1,1,1,1,1, 32'h300, 32'h400, 32'h0, 0, BOOT));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL reset[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
    checks++;
    if (pif.pc_plus !== 32'h4) $display("FAIL reset_pc_plus got %h want 00000004", pif.pc_plus);
    else passes++;
  endtask

  task automatic test_boot;
    step_t t[$];
    step_t e;
    // redirect/halt inputs held high throughout BOOT must be ignored
    t.push_back(s(1,1,1,0,1,1,0, 32'h300, 0, 32'h0, 0, BOOT));
    t.push_back(s(1,1,1,0,1,1,0, 32'h300, 0, 32'h0, 0, BOOT));
    t.push_back(s(1,1,1,0,1,1,0, 32'h300, 0, 32'h0, 0, BOOT));
    t.push_back(s(1,1,1,0,1,1,0, 32'h300, 0, 32'h0, 1, RUN));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h4, 1, RUN));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h8, 1, RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL boot[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
  endtask

  task automatic test_stall;
    step_t t[$];
    step_t e;
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'hC, 1, RUN));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h10, 1, RUN));
    t.push_back(s(1,1,0,0,0,0,0, 0, 0, 32'h10, 1, RUN));
    t.push_back(s(1,1,0,0,0,0,0, 0, 0, 32'h10, 1, RUN));
    t.push_back(s(1,1,0,0,0,0,0, 0, 0, 32'h10, 1, RUN));
    t.push_back(s(1,1,1,0,0,0,0, 32'h200, 0, 32'h200, 1, RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL stall[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
  endtask

  task automatic test_priority;
    step_t t[$];
    step_t e;
    t.push_back(s(1,0,1,1,1,0,0, 32'h300, 32'h400, 32'h100, 1, RUN));
    t.push_back(s(1,0,1,1,0,0,0, 32'h300, 32'h400, 32'h300, 1, RUN));
    t.push_back(s(1,1,0,1,0,0,0, 32'h300, 32'h400, 32'h400, 1, RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL priority[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
    checks++;
    if (pif.pc_plus !== 32'h404) $display("FAIL priority_pc_plus got %h want 00000404", pif.pc_plus);
    else passes++;
  endtask

  task automatic test_halt;
    step_t t[$];
    step_t e;
    t.push_back(s(1,0,0,1,0,0,0, 0, 32'h20, 32'h20, 1, RUN));
    t.push_back(s(1,0,0,0,0,1,0, 0, 0, 32'h24, 0, HALT));
    t.push_back(s(1,1,0,0,0,0,0, 0, 0, 32'h24, 0, HALT));
    t.push_back(s(1,0,1,0,0,0,0, 32'h500, 0, 32'h24, 0, HALT));
    t.push_back(s(1,0,0,1,0,0,0, 0, 32'h600, 32'h24, 0, HALT));
    t.push_back(s(1,1,1,1,0,1,0, 32'h500, 32'h600, 32'h24, 0, HALT));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h24, 0, HALT));
    t.push_back(s(1,0,0,0,0,0,1, 0, 0, 32'h24, 1, RUN));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h28, 1, RUN));
    t.push_back(s(1,0,0,0,0,1,1, 0, 0, 32'h2C, 0, HALT));
    t.push_back(s(1,0,0,0,1,0,1, 0, 0, 32'h100, 1, RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL halt[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
  endtask

  task automatic test_wrap_reset;
    step_t t[$];
    step_t e;
    t.push_back(s(1,0,0,1,0,0,0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL wrap[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
    checks++;
    if (pif.pc_plus !== 32'h0) $display("FAIL wrap_pc_plus got %h want 00000000", pif.pc_plus);
    else passes++;
    t.delete();
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h0, 1, RUN));
    t.push_back(s(1,0,0,0,0,1,0, 0, 0, 32'h4, 0, HALT));
    t.push_back(s(0,0,0,0,1,0,1, 0, 0, 32'h0, 0, BOOT));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h0, 0, BOOT));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h0, 0, BOOT));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h0, 0, BOOT));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h0, 1, RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL midreset[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
  endtask

  task automatic test_align;
    step_t e;
    // 0x102 lands on 0x100 both ways: trap vector when checked, masked otherwise
    drive(s(1,0,0,1,0,0,0, 0, 32'h102, 32'h100, 1, RUN));
    e = exp_q.pop_front();
    checks++;
    if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
      $display("FAIL align_jmp got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
               pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
    else passes++;
`ifdef PC_ALIGN_CHK_EN
    checks++;
    if (pif.misalign_err !== 1'b1 || pif.bad_addr !== 32'h102)
      $display("FAIL align_err got err=%b bad=%h want err=1 bad=00000102", pif.misalign_err, pif.bad_addr);
    else passes++;
`endif
    drive(s(1,0,0,0,0,0,0, 0, 0, 32'h104, 1, RUN));
    e = exp_q.pop_front();
    checks++;
    if (pif.pc_out !== e.pc) $display("FAIL align_next got pc=%h want pc=%h", pif.pc_out, e.pc);
    else passes++;
`ifdef PC_ALIGN_CHK_EN
    checks++;
    if (pif.misalign_err !== 1'b0 || pif.bad_addr !== 32'h102)
      $display("FAIL align_pulse got err=%b bad=%h want err=0 bad=00000102", pif.misalign_err, pif.bad_addr);
    else passes++;
`endif
    drive(s(1,0,1,0,1,0,0, 32'h303, 0, 32'h100, 1, RUN));
    e = exp_q.pop_front();
    checks++;
    if (pif.pc_out !== e.pc) $display("FAIL align_trap got pc=%h want pc=%h", pif.pc_out, e.pc);
    else passes++;
`ifdef PC_ALIGN_CHK_EN
    checks++;
    if (pif.misalign_err !== 1'b0 || pif.bad_addr !== 32'h102)
      $display("FAIL align_trapwin got err=%b bad=%h want err=0 bad=00000102", pif.misalign_err, pif.bad_addr);
    else passes++;
    drive(s(1,0,1,0,0,0,0, 32'h303, 0, 32'h100, 1, RUN));
`else
    drive(s(1,0,1,0,0,0,0, 32'h303, 0, 32'h300, 1, RUN));
`endif
    e = exp_q.pop_front();
    checks++;
    if (pif.pc_out !== e.pc) $display("FAIL align_br got pc=%h want pc=%h", pif.pc_out, e.pc);
    else passes++;
`ifdef PC_ALIGN_CHK_EN
    checks++;
    if (pif.misalign_err !== 1'b1 || pif.bad_addr !== 32'h303)
      $display("FAIL align_br_err got err=%b bad=%h want err=1 bad=00000303", pif.misalign_err, pif.bad_addr);
    else passes++;
`endif
  endtask

  task automatic test_back_to_back;
    step_t t[$];
    step_t e;
    t.push_back(s(1,0,1,0,0,0,0, 32'h500, 0, 32'h500, 1, RUN));
    t.push_back(s(1,0,0,1,0,0,0, 0, 32'h600, 32'h600, 1, RUN));
    t.push_back(s(1,1,1,0,0,0,0, 32'h700, 0, 32'h700, 1, RUN));
    t.push_back(s(1,0,0,0,0,0,0, 0, 0, 32'h704, 1, RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (pif.pc_out !== e.pc || pif.pc_valid !== e.vld || pif.state !== e.s)
        $display("FAIL b2b[%0d] got pc=%h vld=%b st=%b want pc=%h vld=%b st=%b",
                 i, pif.pc_out, pif.pc_valid, pif.state, e.pc, e.vld, e.s);
      else passes++;
    end
  endtask

  initial begin
    reset = 1'b0;
    pif.stall_PC = 0; pif.br_valid = 0; pif.jmp_valid = 0; pif.trap_valid = 0;
    pif.halt_req = 0; pif.resume = 0; pif.br_target = '0; pif.jmp_target = '0;
    #1;
    test_reset();
    test_boot();
    test_stall();
    test_priority();
    test_halt();
    test_wrap_reset();
    test_align();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the 5-stage pipeline's IF stage; the successor to the basic PC register.
- Selects the next PC from prioritised redirect sources: trap, branch, jump, then sequential.
- Honours the hazard-unit stall and holds fetch invalid for a configurable boot delay after reset.
- Provides a halt/resume control FSM for debug and end-of-program handling.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap (and on misalign when the optional feature is enabled).
- INC, 4, sequential increment in bytes.
- BOOT_WAIT, 4, number of cycles spent in BOOT after reset release (0 is legal).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- stall_PC  input  1  hazard-unit stall; holds PC when no redirect is present.
- br_valid  input  1  branch taken, resolved in EX.
- br_target  input  XLEN  branch target.
- jmp_valid  input  1  jal/jalr redirect.
- jmp_target  input  XLEN  jump target.
- trap_valid  input  1  trap/ecall request.
- halt_req  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- pc_out  output  XLEN  current fetch PC (registered).
- pc_plus  output  XLEN  pc_out + INC (combinational).
- pc_valid  output  1  pc_out is a valid fetch address (registered).
- state  output  2  FSM state: 00 BOOT, 01 RUN, 10 HALT.
- misalign_err  output  1  exists only with PC_ALIGN_CHK_EN.
- bad_addr  output  XLEN  exists only with PC_ALIGN_CHK_EN.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - When reset==0 at an edge: pc_out=RESET_VECTOR, pc_valid=0, state=BOOT, boot counter=0, misalign_err=0, bad_addr=0.
  - Reset overrides all other inputs, including mid-HALT or mid-redirect.
- BOOT:
  - pc_out holds RESET_VECTOR and pc_valid=0; the counter increments each cycle.
  - When counter==BOOT_WAIT-1, the next edge moves to RUN and sets pc_valid=1.
  - With BOOT_WAIT=0, the first edge after reset release moves to RUN.
  - All redirect, stall and halt inputs are ignored in BOOT.
- RUN, next-PC priority:
  - trap_valid → TRAP_VECTOR.
  - else br_valid → br_target.
  - else jmp_valid → jmp_target.
  - else stall_PC → hold.
  - else pc_out + INC.
  - Redirects override stall_PC; a stall only holds sequential flow.
  - One-cycle latency: a redirect sampled at edge N appears on pc_out after edge N.
  - Sequential increment wraps modulo 2^XLEN (e.g. FFFF_FFFC + 4 = 0000_0000).
- Halt:
  - halt_req in RUN: the next PC is still computed and applied at that edge; state becomes HALT and pc_valid becomes 0.
  - HALT: pc_out holds and pc_valid=0.
  - resume → RUN with pc_valid=1 and the same pc_out.
  - trap_valid in HALT → pc_out=TRAP_VECTOR, RUN, pc_valid=1; trap wins over resume.
  - br/jmp/stall are ignored in HALT.
  - halt_req and resume both high in RUN → HALT.
- Target alignment: without the optional feature, bits [1:0] of any loaded redirect target are forced to 0.
- pc_plus is always pc_out + INC truncated to XLEN, independent of state.

Optional Feature:
- Macro PC_ALIGN_CHK_EN.
- Enabled:
  - A br/jmp redirect whose selected target has [1:0]!=0 loads TRAP_VECTOR instead.
  - misalign_err pulses 1 for exactly one cycle, aligned with pc_out=TRAP_VECTOR.
  - bad_addr captures the raw target and holds it until the next misalign or reset.
  - A simultaneous trap_valid takes precedence: no misalign_err pulse and bad_addr unchanged.
- Disabled: misalign_err and bad_addr ports are absent; the target LSBs are masked as described under Behaviour.

Test Plan:
- Boot: reset=0 for 2 cycles, release with BOOT_WAIT=4 → state=00 and pc_valid=0 for 4 cycles, then state=01, pc_valid=1, pc_out=0x0, then 0x4, 0x8 on successive cycles.
- Stall vs redirect: in RUN at pc=0x10, stall_PC=1 for 3 cycles → pc_out stays 0x10; stall_PC=1 with br_valid=1, br_target=0x200 → pc_out=0x200 next cycle.
- Priority: trap_valid, br_valid (0x300) and jmp_valid (0x400) together → pc_out=0x100; br (0x300) with jmp (0x400) → 0x300.
- Halt/resume: halt_req at pc=0x20 → pc_out=0x24, state=10, pc_valid=0, held 5 cycles; resume → state=01, pc_valid=1, then 0x28; trap in HALT → 0x100.
- Wrap and mid-op reset: force pc to 0xFFFF_FFFC → next 0x0; assert reset during HALT → pc_out=0x0, state=00, pc_valid=0 on the next edge.
- PC_ALIGN_CHK_EN: jmp_target=0x0000_0102 → pc_out=0x100, misalign_err=1 for one cycle, bad_addr=0x0000_0102; without the macro → pc_out=0x100 via masking, no error port.
